// File: rtl/ysyx_220053_mem_pkg.sv
// Shared types and constants for the arbiter-to-memory bridge.
package ysyx_220053_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } mb_state_t;

    localparam logic [3:0] DEV_REGION = 4'ha;
    localparam int         BEAT_BYTES = 8;
    localparam int         LINE_BYTES = 16;

    // Device space is the 0xA000_0000 - 0xAFFF_FFFF window of the low 32 bits.
    function automatic logic is_dev_addr(input logic [63:0] addr);
        return addr[31:28] == DEV_REGION;
    endfunction

endpackage

// File: rtl/ysyx_220053_mem_bridge.sv
// Converts one arbiter line request into two 64-bit memory beats (or a single
// beat for device space) and returns the assembled line with a ready pulse.
module ysyx_220053_mem_bridge
    import ysyx_220053_mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 128,
    parameter int BEAT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rw_addr_i,
    input  logic                  rw_req_i,
    input  logic                  rw_valid_i,
    input  logic [LINE_W-1:0]     rw_w_data_i,
    output logic [LINE_W-1:0]     data_read_o,
    output logic                  rw_ready_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_valid_o,
    output logic                  mem_wen_o,
    output logic [BEAT_W-1:0]     mem_wdata_o,
    output logic [BEAT_W/8-1:0]   mem_wmask_o,
    input  logic                  mem_ready_i,
    input  logic [BEAT_W-1:0]     mem_rdata_i
);

    mb_state_t          state;
    mb_state_t          state_nxt;
    logic               req_q;
    logic               dev_q;
    logic [ADDR_W-1:0]  base_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;

    // Device accesses align to a beat, line accesses align to a whole line.
    function automatic logic [ADDR_W-1:0] access_base(input logic [ADDR_W-1:0] addr,
                                                      input logic              dev);
        logic [ADDR_W-1:0] mask;
        mask = dev ? ~ADDR_W'(BEAT_BYTES - 1) : ~ADDR_W'(LINE_BYTES - 1);
        return addr & mask;
    endfunction

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: beats advance only on mem_ready_i, RESP lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rw_valid_i)  state_nxt = BEAT0;
            BEAT0:   if (mem_ready_i) state_nxt = dev_q ? RESP : BEAT1;
            BEAT1:   if (mem_ready_i) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture in IDLE so the arbiter's inputs are free to change afterwards.
    always_ff @(posedge clk) begin
        if (state == IDLE && rw_valid_i) begin
            req_q   <= rw_req_i;
            dev_q   <= is_dev_addr(64'(rw_addr_i));
            base_q  <= access_base(rw_addr_i, is_dev_addr(64'(rw_addr_i)));
            wdata_q <= rw_w_data_i;
        end
    end

    // Read line assembly; writes never touch it, device reads zero the upper beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (!req_q && mem_ready_i) begin
            if (state == BEAT0) begin
                rdata_q[BEAT_W-1:0] <= mem_rdata_i;
                if (dev_q) begin
                    rdata_q[LINE_W-1:BEAT_W] <= '0;
                end
            end else if (state == BEAT1) begin
                rdata_q[LINE_W-1:BEAT_W] <= mem_rdata_i;
            end
        end
    end

    // Bus outputs decoded purely from registered state; all zero outside the beats.
    always_comb begin
        rw_ready_o  = 1'b0;
        mem_valid_o = 1'b0;
        mem_wen_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        case (state)
            BEAT0: begin
                mem_valid_o = 1'b1;
                mem_wen_o   = req_q;
                mem_addr_o  = base_q;
                mem_wdata_o = wdata_q[BEAT_W-1:0];
                mem_wmask_o = {(BEAT_W/8){req_q}};
            end
            BEAT1: begin
                mem_valid_o = 1'b1;
                mem_wen_o   = req_q;
                // base_q is line aligned, so OR-ing in the beat offset never carries.
                mem_addr_o  = base_q | ADDR_W'(BEAT_BYTES);
                mem_wdata_o = wdata_q[LINE_W-1:BEAT_W];
                mem_wmask_o = {(BEAT_W/8){req_q}};
            end
            RESP: begin
                rw_ready_o = 1'b1;
            end
            default: begin
                rw_ready_o = 1'b0;
            end
        endcase
    end

    assign data_read_o = rdata_q;

endmodule

// File: tb/tb_ysyx_220053_mem_bridge.sv
// Self-checking bench for ysyx_220053_mem_bridge: transaction-level reference
// model compared every cycle, plus directed literal checks.
module tb_ysyx_220053_mem_bridge;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   rw_addr_i;
    logic          rw_req_i;
    logic          rw_valid_i;
    logic [127:0]  rw_w_data_i;
    logic [127:0]  data_read_o;
    logic          rw_ready_o;
    logic [63:0]   mem_addr_o;
    logic          mem_valid_o;
    logic          mem_wen_o;
    logic [63:0]   mem_wdata_o;
    logic [7:0]    mem_wmask_o;
    logic          mem_ready_i;
    logic [63:0]   mem_rdata_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // One expected bus action: a beat (held until accepted) or the ready pulse.
    typedef struct {
        bit          resp;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        int          half;
        bit          dev;
    } step_t;

    step_t        q[$];
    logic [127:0] exp_data = '0;

    ysyx_220053_mem_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .rw_addr_i   (rw_addr_i),
        .rw_req_i    (rw_req_i),
        .rw_valid_i  (rw_valid_i),
        .rw_w_data_i (rw_w_data_i),
        .data_read_o (data_read_o),
        .rw_ready_o  (rw_ready_o),
        .mem_addr_o  (mem_addr_o),
        .mem_valid_o (mem_valid_o),
        .mem_wen_o   (mem_wen_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a request expands into a list of bus actions.
    task automatic model_step();
        step_t       s;
        logic [63:0] base;
        bit          dev;
        if (!rst) begin
            q.delete();
            exp_data = '0;
        end else if (q.size() == 0) begin
            if (rw_valid_i) begin
                dev  = (rw_addr_i[31:28] == 4'ha);
                base = dev ? (rw_addr_i / 8) * 8 : (rw_addr_i / 16) * 16;
                s.resp  = 1'b0;
                s.addr  = base;
                s.wen   = rw_req_i;
                s.wdata = rw_w_data_i[63:0];
                s.half  = 0;
                s.dev   = dev;
                q.push_back(s);
                if (!dev) begin
                    s.addr  = base + 64'd8;
                    s.wdata = rw_w_data_i[127:64];
                    s.half  = 1;
                    q.push_back(s);
                end
                s.resp = 1'b1;
                q.push_back(s);
            end
        end else if (q[0].resp) begin
            void'(q.pop_front());
        end else if (mem_ready_i) begin
            s = q.pop_front();
            if (!s.wen) begin
                if (s.half == 0) exp_data[63:0]   = mem_rdata_i;
                else             exp_data[127:64] = mem_rdata_i;
                if (s.dev)       exp_data[127:64] = '0;
            end
        end
    endtask

    task automatic compare();
        logic        e_rdy, e_vld, e_wen;
        logic [63:0] e_addr, e_wd;
        logic [7:0]  e_msk;
        e_rdy = 0; e_vld = 0; e_wen = 0; e_addr = '0; e_wd = '0; e_msk = '0;
        if (q.size() > 0) begin
            if (q[0].resp) begin
                e_rdy = 1;
            end else begin
                e_vld  = 1;
                e_wen  = q[0].wen;
                e_addr = q[0].addr;
                e_wd   = q[0].wdata;
                e_msk  = q[0].wen ? 8'hff : 8'h00;
            end
        end
        check("rw_ready_o",  128'(rw_ready_o),  128'(e_rdy));
        check("mem_valid_o", 128'(mem_valid_o), 128'(e_vld));
        check("mem_wen_o",   128'(mem_wen_o),   128'(e_wen));
        check("mem_addr_o",  128'(mem_addr_o),  128'(e_addr));
        check("mem_wdata_o", 128'(mem_wdata_o), 128'(e_wd));
        check("mem_wmask_o", 128'(mem_wmask_o), 128'(e_msk));
        check("data_read_o", data_read_o,       exp_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic run_txn(input logic [63:0] a, input logic rq, input logic [127:0] wd,
                           input int stalls, input bit rnd,
                           input logic [63:0] rd0, input logic [63:0] rd1,
                           output int lat, output logic [127:0] dr,
                           output logic [63:0] ba0, output logic [63:0] ba1,
                           output logic [63:0] bw0, output logic [63:0] bw1);
        int   nb;
        bit   done;
        logic v;
        nb = 0; done = 0; lat = 0; dr = '0;
        ba0 = '0; ba1 = '0; bw0 = '0; bw1 = '0;
        rw_addr_i = a; rw_req_i = rq; rw_w_data_i = wd; rw_valid_i = 1'b1;
        for (int k = 1; k <= 200 && !done; k++) begin
            if (rnd) mem_ready_i = ($urandom_range(0, 3) != 0);
            else     mem_ready_i = !(k >= 2 && k <= stalls + 1);
            mem_rdata_i = (nb == 0) ? rd0 : rd1;
            v = mem_valid_o;
            if (v && mem_ready_i) begin
                if (nb == 0) begin ba0 = mem_addr_o; bw0 = mem_wdata_o; end
                else         begin ba1 = mem_addr_o; bw1 = mem_wdata_o; end
            end
            tick();
            if (v && mem_ready_i) nb++;
            if (k == 1 && rnd) begin
                rw_addr_i   = {$urandom(), $urandom()};
                rw_req_i    = $urandom_range(0, 1) == 1;
                rw_w_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (rw_ready_o) begin
                done = 1;
                lat  = k;
                dr   = data_read_o;
            end
        end
        check("txn_done", 128'(done), 128'(1));
        rw_valid_i  = 1'b0;
        mem_ready_i = 1'b0;
        tick();
    endtask

    initial begin
        int           lat;
        logic [127:0] dr;
        logic [63:0]  ba0, ba1, bw0, bw1;
        logic [63:0]  a;
        int           np;
        int           t1, t2;

        rst = 1'b0; rw_addr_i = '0; rw_req_i = 1'b0; rw_valid_i = 1'b0;
        rw_w_data_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
        tick();
        tick();
        check("reset_valid", 128'(mem_valid_o), 128'(0));
        check("reset_data",  data_read_o,       128'(0));
        check("reset_addr",  128'(mem_addr_o),  128'(0));
        rst = 1'b1;
        tick();

        // Line read, no stalls
        run_txn(64'h8000_0014, 1'b0, '0, 0, 1'b0,
                64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, lat, dr, ba0, ba1, bw0, bw1);
        check("rd_latency", 128'(lat), 128'(3));
        check("rd_beat0",   128'(ba0), 128'(64'h8000_0010));
        check("rd_beat1",   128'(ba1), 128'(64'h8000_0018));
        check("rd_line",    dr, 128'h2222_2222_2222_2222_1111_1111_1111_1111);
        check("rd_pulse_w", 128'(rw_ready_o), 128'(0));

        // Line write with two stall cycles on beat 0
        run_txn(64'h8000_0020, 1'b1, 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB, 2, 1'b0,
                64'h0, 64'h0, lat, dr, ba0, ba1, bw0, bw1);
        check("wr_latency", 128'(lat), 128'(5));
        check("wr_beat0_a", 128'(ba0), 128'(64'h8000_0020));
        check("wr_beat1_a", 128'(ba1), 128'(64'h8000_0028));
        check("wr_beat0_d", 128'(bw0), 128'(64'hBBBB_BBBB_BBBB_BBBB));
        check("wr_beat1_d", 128'(bw1), 128'(64'hAAAA_AAAA_AAAA_AAAA));
        check("wr_keep_rd", dr, 128'h2222_2222_2222_2222_1111_1111_1111_1111);

        // Device read
        run_txn(64'hA000_03F8, 1'b0, '0, 0, 1'b0,
                64'h42, 64'hDEAD_BEEF_DEAD_BEEF, lat, dr, ba0, ba1, bw0, bw1);
        check("dev_latency", 128'(lat), 128'(2));
        check("dev_addr",    128'(ba0), 128'(64'hA000_03F8));
        check("dev_line",    dr,        128'h42);

        // Reset during BEAT1
        rw_addr_i = 64'h8000_0040; rw_req_i = 1'b0; rw_valid_i = 1'b1;
        mem_ready_i = 1'b1; mem_rdata_i = 64'h5555_6666_7777_8888;
        tick();
        tick();
        check("pre_rst_valid", 128'(mem_valid_o), 128'(1));
        check("pre_rst_addr",  128'(mem_addr_o),  128'(64'h8000_0048));
        rst = 1'b0; rw_valid_i = 1'b0;
        tick();
        check("rst_valid", 128'(mem_valid_o), 128'(0));
        check("rst_ready", 128'(rw_ready_o),  128'(0));
        check("rst_data",  data_read_o,       128'(0));
        rst = 1'b1; mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_pulse", 128'(rw_ready_o), 128'(0));
        end
        run_txn(64'h8000_0050, 1'b0, '0, 0, 1'b0,
                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, lat, dr, ba0, ba1, bw0, bw1);
        check("post_rst_lat",  128'(lat), 128'(3));
        check("post_rst_line", dr, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);

        // Back-to-back line reads with valid held high
        rw_addr_i = 64'h8000_0100; rw_req_i = 1'b0; rw_valid_i = 1'b1; mem_ready_i = 1'b1;
        np = 0; t1 = 0; t2 = 0;
        for (int i = 1; i <= 12; i++) begin
            mem_rdata_i = {$urandom(), $urandom()};
            tick();
            if (rw_ready_o) begin
                np++;
                if (np == 1) t1 = i;
                if (np == 2) begin
                    t2 = i;
                    rw_valid_i = 1'b0;
                end
            end
        end
        check("b2b_pulses", 128'(np),      128'(2));
        check("b2b_gap",    128'(t2 - t1), 128'(4));
        mem_ready_i = 1'b0;
        tick();

        // Randomized traffic with random stalls and inputs scrambled mid-transaction
        for (int n = 0; n < 40; n++) begin
            a = {$urandom(), $urandom()};
            a[31:28] = ($urandom_range(0, 2) == 0) ? 4'ha : 4'h8;
            run_txn(a, $urandom_range(0, 1) == 1,
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1,
                    {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    lat, dr, ba0, ba1, bw0, bw1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
